ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; sends one command byte (e.g. ED LED set, FF reset, F3 typematic) to the attached keyboard.
- Sits beside the PS/2 receiver on the same clock/data pins. Drives open-drain lines via active-high "drive low" enables; the top level ties them to tristate pads.
- Implements the full host request: clock inhibit, start, 8 data bits LSB first, odd parity, stop, then device ACK check and timeout abort.

---
 rtl/ps2_host_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// -----------------------------------------------------------------------------
// PS/2 host-to-device transmitter. Sends one command byte to the attached
// device: inhibits the clock, issues the request-to-send (data low), then
// shifts 8 data bits LSB first, odd parity and the stop bit on the device's
// falling clock edges. Afterwards it checks the device ACK and waits for the
// bus to go idle. A watchdog aborts the frame if the device stops clocking.
//
// Ports
//   clk                 system clock
//   reset               synchronous active-high reset
//   tx_data[7:0]        byte to send, captured when tx_valid && tx_ready
//   tx_valid            send request
//   tx_ready            high only while idle
//   done                one-cycle pulse: frame sent and ACK received
//   err                 one-cycle pulse: missing ACK or timeout
//   ps2_clk_in          raw ps2 clock pin level
//   ps2_data_in         raw ps2 data pin level
//   ps2_clk_drive_low   1 = pull ps2 clock low (open-drain enable)
//   ps2_data_drive_low  1 = pull ps2 data low (open-drain enable)
//
// Parameters
//   LEN             ps2 clock filter depth (LEN+1 sample shift register)
//   INHIBIT_CYCLES  clk cycles the ps2 clock is held low for the request
//                   (the final one of these is the REQ cycle with data low)
//   TIMEOUT_CYCLES  max clk cycles without a device falling edge
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int LEN            = 8,
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // INHIBIT spans INHIBIT_CYCLES-1 cycles and REQ one more, so the clock is
  // held low for exactly INHIBIT_CYCLES cycles in total.
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bitcnt_reg, bitcnt_next;
  logic [7:0]       shreg_reg, shreg_next;
  logic             parity_reg, parity_next;
  logic             clk_dl_reg, clk_dl_next;
  logic             data_dl_reg, data_dl_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [LEN:0]     stable_reg;
  logic             bitclk_reg;
  logic             data_sync_reg;
  logic             fall;
  logic             accept;
  logic             to_hit;

  assign accept = tx_valid && (state_reg == S_IDLE);
  assign to_hit = (cnt_reg == TO_LAST);
  assign fall   = bitclk_reg & ~|stable_reg[LEN-1:0];

  // Clock glitch filter and data synchroniser. bitclk is also cleared on the
  // cycle fall is seen so that fall is a single-cycle pulse per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_reg    <= '1;
      bitclk_reg    <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      stable_reg    <= {stable_reg[LEN-1:0], ps2_clk_in};
      data_sync_reg <= ps2_data_in;
      if (&stable_reg) begin
        bitclk_reg <= 1'b1;
      end else if (fall || ~|stable_reg) begin
        bitclk_reg <= 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bitcnt_reg  <= '0;
      shreg_reg   <= '0;
      parity_reg  <= 1'b0;
      clk_dl_reg  <= 1'b0;
      data_dl_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bitcnt_reg  <= bitcnt_next;
      shreg_reg   <= shreg_next;
      parity_reg  <= parity_next;
      clk_dl_reg  <= clk_dl_next;
      data_dl_reg <= data_dl_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic. A device edge takes priority over the watchdog.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:      if (accept) state_next = S_INHIBIT;
      S_INHIBIT:   if (cnt_reg == INH_LAST) state_next = S_REQ;
      S_REQ:       state_next = S_XFER;
      S_XFER: begin
        if (fall) begin
          if (bitcnt_reg == 4'd9) state_next = S_ACK;
        end else if (to_hit) begin
          state_next = S_IDLE;
        end
      end
      S_ACK: begin
        if (fall) state_next = data_sync_reg ? S_IDLE : S_WAIT_IDLE;
        else if (to_hit) state_next = S_IDLE;
      end
      S_WAIT_IDLE: begin
        if (data_sync_reg && bitclk_reg) state_next = S_IDLE;
        else if (to_hit) state_next = S_IDLE;
      end
      default:     state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    cnt_next     = cnt_reg;
    bitcnt_next  = bitcnt_reg;
    shreg_next   = shreg_reg;
    parity_next  = parity_reg;
    clk_dl_next  = clk_dl_reg;
    data_dl_next = data_dl_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        clk_dl_next  = 1'b0;
        data_dl_next = 1'b0;
        cnt_next     = '0;
        if (accept) begin
          shreg_next  = tx_data;
          parity_next = ~^tx_data;
          bitcnt_next = '0;
          clk_dl_next = 1'b1;
        end
      end
      S_INHIBIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == INH_LAST) data_dl_next = 1'b1;
      end
      S_REQ: begin
        // Releasing the clock with data low is the start bit.
        clk_dl_next = 1'b0;
        cnt_next    = '0;
      end
      S_XFER: begin
        if (fall) begin
          cnt_next    = '0;
          bitcnt_next = bitcnt_reg + 4'd1;
          if (bitcnt_reg < 4'd8)       data_dl_next = ~shreg_reg[bitcnt_reg[2:0]];
          else if (bitcnt_reg == 4'd8) data_dl_next = ~parity_reg;
          else                         data_dl_next = 1'b0;
        end else if (to_hit) begin
          clk_dl_next  = 1'b0;
          data_dl_next = 1'b0;
          err_next     = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_next = '0;
          err_next = data_sync_reg;
        end else if (to_hit) begin
          clk_dl_next  = 1'b0;
          data_dl_next = 1'b0;
          err_next     = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (data_sync_reg && bitclk_reg) begin
          done_next = 1'b1;
          cnt_next  = '0;
        end else if (to_hit) begin
          clk_dl_next  = 1'b0;
          data_dl_next = 1'b0;
          err_next     = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        clk_dl_next  = 1'b0;
        data_dl_next = 1'b0;
        cnt_next     = '0;
      end
    endcase
  end

  assign tx_ready           = (state_reg == S_IDLE);
  assign done               = done_reg;
  assign err                = err_reg;
  assign ps2_clk_drive_low  = clk_dl_reg;
  assign ps2_data_drive_low = data_dl_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus model plus a PS/2 device model
// (40-cycle clock period). Expected per-cycle output levels and pulses are
// written into timeline arrays from the protocol rules as each event is
// scheduled; one process compares every cycle against them.
module tb_ps2_host_tx;
  localparam int LEN  = 8;
  localparam int INH  = 20;
  localparam int TO   = 2000;
  localparam int MAXC = 8192;
  localparam int HALF = 20;
  // Pin drop -> fall pulse after LEN low samples -> registered reaction.
  localparam int FALL_LAT = LEN + 1;
  // Pin release -> LEN+1 high samples -> bitclk -> registered done.
  localparam int RISE_LAT = LEN + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, done, err;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_bus, ps2_data_bus;

  assign ps2_clk_bus  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_bus = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(.LEN(LEN), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .done(done), .err(err),
    .ps2_clk_in(ps2_clk_bus), .ps2_data_in(ps2_data_bus),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  bit exp_ready[MAXC];
  bit exp_cdl[MAXC];
  bit exp_ddl[MAXC];
  bit exp_done[MAXC];
  bit exp_err[MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Level expectation: signal holds v from cycle 'from' onward.
  task automatic set_lvl(input int sig, input int from, input bit v);
    for (int i = from; i < MAXC; i++) begin
      if (i >= 0) begin
        case (sig)
          0:       exp_ready[i] = v;
          1:       exp_cdl[i] = v;
          default: exp_ddl[i] = v;
        endcase
      end
    end
  endtask

  task automatic set_pulse(input int sig, input int at);
    if (at >= 0 && at < MAXC) begin
      if (sig == 0) exp_done[at] = 1'b1;
      else          exp_err[at] = 1'b1;
    end
  endtask

  // Bits seen on the wire at device rising edges: start, data LSB first,
  // odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("tx_ready", 32'(tx_ready), 32'(exp_ready[cyc]));
      chk("clk_drive_low", 32'(ps2_clk_drive_low), 32'(exp_cdl[cyc]));
      chk("data_drive_low", 32'(ps2_data_drive_low), 32'(exp_ddl[cyc]));
      chk("done", 32'(done), 32'(exp_done[cyc]));
      chk("err", 32'(err), 32'(exp_err[cyc]));
    end
  end

  // One host request against the device model. abort_at>0 resets the DUT
  // after that device falling edge; ff_pulse offers 8'hFF mid-transfer.
  task automatic run_frame(input logic [7:0] d, input bit do_ack, input bit do_clock,
                           input int abort_at, input bit ff_pulse, input logic [10:0] lit);
    int a, r, c, u, k, e;
    logic [10:0] samp, fr;
    bit aborted;
    fr = frame_of(d);
    samp = '0;
    aborted = 1'b0;
    tx_data = d;
    tx_valid = 1'b1;
    a = cyc + 1;
    set_lvl(0, a, 1'b0);
    set_lvl(1, a, 1'b1);
    set_lvl(2, a + INH - 1, 1'b1);
    set_lvl(1, a + INH, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    r = -1;
    for (int n = 0; n < 100 && r < 0; n++) begin
      if (ps2_clk_bus && !ps2_data_bus) r = cyc;
      else @(negedge clk);
    end
    if (r < 0) begin
      chk("request_seen", 32'd0, 32'd1);
      return;
    end
    chk("inhibit_len", 32'(r - a), 32'd20);
    samp[0] = ps2_data_bus;
    if (!do_clock) begin
      set_pulse(1, r + TO);
      set_lvl(0, r + TO, 1'b1);
      set_lvl(2, r + TO, 1'b0);
      e = -1;
      for (int n = 0; n < TO + 50 && e < 0; n++) begin
        @(negedge clk);
        if (err) e = cyc;
      end
      chk("timeout_latency", 32'(e - r), 32'd2000);
      repeat (40) @(negedge clk);
      return;
    end
    for (int i = 1; i <= 11; i++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      if (i == 11 && do_ack) dev_data_low = 1'b1;
      c = cyc;
      if (i <= 10) set_lvl(2, c + FALL_LAT, ~fr[i]);
      if (i == 11 && !do_ack) begin
        set_pulse(1, c + FALL_LAT);
        set_lvl(0, c + FALL_LAT, 1'b1);
      end
      if (i == abort_at) begin
        repeat (FALL_LAT + 1) @(negedge clk);
        reset = 1'b1;
        dev_clk_low = 1'b0;
        k = cyc;
        set_lvl(0, k + 1, 1'b1);
        set_lvl(1, k + 1, 1'b0);
        set_lvl(2, k + 1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
        break;
      end
      for (int t = 0; t < HALF; t++) begin
        @(negedge clk);
        if (ff_pulse && i == 3 && t == 5) begin
          tx_valid = 1'b1;
          tx_data = 8'hFF;
        end else if (ff_pulse && i == 3 && t == 6) begin
          tx_valid = 1'b0;
          tx_data = d;
        end
      end
      if (i <= 10) samp[i] = ps2_data_bus;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      u = cyc;
      if (i == 11 && do_ack) begin
        set_pulse(0, u + RISE_LAT);
        set_lvl(0, u + RISE_LAT, 1'b1);
      end
    end
    if (!aborted) begin
      chk("frame_vs_model", 32'(samp), 32'(fr));
      chk("frame_vs_literal", 32'(samp), 32'(lit));
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    set_lvl(0, 0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", 32'(tx_ready), 32'd1);
    chk("reset_clk_dl", 32'(ps2_clk_drive_low), 32'd0);
    chk("reset_data_dl", 32'(ps2_data_drive_low), 32'd0);
    repeat (5) @(negedge clk);
    // ED: 6 ones -> parity 1
    run_frame(8'hED, 1'b1, 1'b1, 0, 1'b0, 11'b11111011010);
    // 00 -> parity 1, 01 -> parity 0
    run_frame(8'h00, 1'b1, 1'b1, 0, 1'b0, 11'b11000000000);
    run_frame(8'h01, 1'b1, 1'b1, 0, 1'b0, 11'b10000000010);
    // no ACK from device
    run_frame(8'hED, 1'b0, 1'b1, 0, 1'b0, 11'b11111011010);
    // device never clocks
    run_frame(8'hED, 1'b1, 1'b0, 0, 1'b0, 11'b11111011010);
    // reset after the 4th fall, then a fresh F3 request
    run_frame(8'hED, 1'b1, 1'b1, 4, 1'b0, 11'b11111011010);
    run_frame(8'hF3, 1'b1, 1'b1, 0, 1'b0, 11'b11111100110);
    // FF offered mid-transfer must be ignored
    run_frame(8'hED, 1'b1, 1'b1, 0, 1'b1, 11'b11111011010);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
